// File: rtl/lfsr_counter_pkg.sv
// Shared mode encodings and default maximal-length Galois tap masks for lfsr_counter_gen.
package lfsr_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_LFSR = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Right-shifting Galois masks; bit WIDTH-1 is always set so the period is 2^WIDTH-1.
    function automatic logic [31:0] default_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_counter_gen_lfsr_next.sv
// Combinational Galois LFSR successor: shift right, fold TAPS in when the outgoing bit is 1.
module lfsr_next #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_counter_gen.sv
// Up/down/LFSR sequence register with seed capture, wrap pulse and tri-state bus output.
// Optional build macro: LFSR_LOCKUP_GUARD_EN (recover from the all-zero LFSR state).
module lfsr_counter_gen
    import lfsr_counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    input  logic             oe,
    output tri   [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] lfsr_nxt;

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr_next (
        .cur (value_q),
        .nxt (lfsr_nxt)
    );

    always_comb begin
        value_d = value_q;
        seed_d  = seed_q;
        wrap_d  = 1'b0;
        if (load) begin
            value_d = load_data;
            seed_d  = load_data;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    value_d = value_q + 1'b1;
                    wrap_d  = (value_d == '0);
                end
                MODE_DOWN: begin
                    value_d = value_q - 1'b1;
                    wrap_d  = (value_d == '1);
                end
                MODE_LFSR: begin
`ifdef LFSR_LOCKUP_GUARD_EN
                    if (value_q == '0) begin
                        value_d = RESET_VAL;
                        wrap_d  = 1'b1;
                    end else begin
                        value_d = lfsr_nxt;
                        wrap_d  = (lfsr_nxt == seed_q);
                    end
`else
                    // Zero is a fixed point here; wrap follows only if the seed was zero too.
                    value_d = lfsr_nxt;
                    wrap_d  = (lfsr_nxt == seed_q);
`endif
                end
                default: begin
                    value_d = value_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= RESET_VAL;
            seed_q  <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            seed_q  <= seed_d;
            wrap_q  <= wrap_d;
        end
    end

    assign value = value_q;
    assign wrap  = wrap_q;
    assign bus   = oe ? value_q : 'z;

endmodule

// File: tb/tb_lfsr_counter_gen.sv
// Randomized and directed checks of lfsr_counter_gen against a behavioural sequence model.
`timescale 1ns/1ps
module tb_lfsr_counter_gen;

    localparam int       W    = 8;
    localparam logic [7:0] TPS = 8'hB8;
    localparam logic [7:0] RV  = 8'h01;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_data;
    logic         en;
    logic         oe;
    tri   [W-1:0] bus;
    logic [W-1:0] value;
    logic         wrap;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_val, m_seed;
    logic         m_wrap;

    lfsr_counter_gen #(.WIDTH(W), .TAPS(TPS), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .mode(mode), .load(load), .load_data(load_data),
        .en(en), .oe(oe), .bus(bus), .value(value), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".value"}, {24'h0, value}, {24'h0, m_val});
        chk({tag, ".wrap"}, {31'h0, wrap}, {31'h0, m_wrap});
        if (oe) chk({tag, ".bus"}, {24'h0, bus}, {24'h0, m_val});
        else    chk({tag, ".busz"}, {24'h0, bus}, {24'h0, 8'hzz});
    endtask

    // Model one clock edge from the current inputs, then compare the DUT just after it.
    task automatic tick(input string tag);
        logic [W-1:0] nv;
        logic         nw;
        nv = m_val;
        nw = 1'b0;
        if (load) begin
            nv = load_data;
            m_seed = load_data;
        end else if (en) begin
            case (mode)
                2'd0: begin nv = m_val + 8'd1; nw = (nv == 8'h00); end
                2'd1: begin nv = m_val - 8'd1; nw = (nv == 8'hFF); end
                2'd2: begin
`ifdef LFSR_LOCKUP_GUARD_EN
                    if (m_val == 8'h00) begin nv = RV; nw = 1'b1; end
                    else begin
                        nv = (m_val >> 1) ^ (m_val[0] ? TPS : 8'h00);
                        nw = (nv == m_seed);
                    end
`else
                    nv = (m_val >> 1) ^ (m_val[0] ? TPS : 8'h00);
                    nw = (nv == m_seed);
`endif
                end
                default: nv = m_val;
            endcase
        end
        @(posedge clk);
        #1;
        m_val  = nv;
        m_wrap = nw;
        chk_outputs(tag);
    endtask

    task automatic model_reset();
        m_val  = RV;
        m_seed = RV;
        m_wrap = 1'b0;
    endtask

    initial begin
        logic [255:0] seen;
        int           repeats;

        rst = 1'b1; mode = 2'd0; load = 1'b0; load_data = '0; en = 1'b0; oe = 1'b0;
        model_reset();
        #12;
        chk_outputs("reset");
        oe = 1'b1;
        #1;
        chk("reset_oe_bus", {24'h0, bus}, 32'h01);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Up mode wrap through FF -> 00
        mode = 2'd0; load = 1'b1; load_data = 8'hFE;
        tick("up_load");
        load = 1'b0; en = 1'b1;
        tick("up_ff");
        chk("up_ff_const", {24'h0, value}, 32'hFF);
        tick("up_00");
        chk("up_wrap_const", {31'h0, wrap}, 32'h1);
        en = 1'b0;
        tick("up_idle");
        chk("up_wrap_once", {31'h0, wrap}, 32'h0);

        // Down mode wrap 00 -> FF
        mode = 2'd1; load = 1'b1; load_data = 8'h00;
        tick("dn_load");
        load = 1'b0; en = 1'b1;
        tick("dn_ff");
        chk("dn_wrap_const", {31'h0, wrap}, 32'h1);
        tick("dn_fe");
        chk("dn_fe_const", {24'h0, value}, 32'hFE);

        // Full LFSR period from seed 01
        mode = 2'd2; en = 1'b0; load = 1'b1; load_data = 8'h01;
        tick("lf_load");
        load = 1'b0; en = 1'b1;
        seen = '0; repeats = 0;
        for (int i = 1; i <= 255; i++) begin
            tick("lf_step");
            if (i == 1) chk("lf_first", {24'h0, value}, 32'hB8);
            chk("lf_wrap_pos", {31'h0, wrap}, {31'h0, (i == 255)});
            if (seen[value]) repeats++;
            seen[value] = 1'b1;
        end
        chk("lf_back_to_seed", {24'h0, value}, 32'h01);
        chk("lf_repeats", repeats, 0);
        chk("lf_visited", $countones(seen), 255);
        chk("lf_zero_unvisited", {31'h0, seen[0]}, 32'h0);

        // Load beats enable
        load = 1'b1; load_data = 8'h3C;
        tick("ld_over_en");
        chk("ld_over_en_const", {24'h0, value}, 32'h3C);

        // Async reset mid-run in LFSR mode
        load = 1'b0;
        repeat (5) tick("lf_run");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_outputs("async_rst");
        @(posedge clk); #3;
        rst = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick("post_rst");
            chk("post_rst_wrap", {31'h0, wrap}, {31'h0, (i == 255)});
        end

        // LFSR zero-state behaviour
        load = 1'b1; load_data = 8'h00;
        tick("lz_load");
        load = 1'b0;
        tick("lz_step");
`ifdef LFSR_LOCKUP_GUARD_EN
        chk("lz_value", {24'h0, value}, 32'h01);
`else
        chk("lz_value", {24'h0, value}, 32'h00);
`endif
        chk("lz_wrap", {31'h0, wrap}, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mode      = 2'($urandom_range(0, 3));
            load      = ($urandom_range(0, 15) == 0);
            load_data = 8'($urandom);
            en        = ($urandom_range(0, 3) != 0);
            oe        = ($urandom_range(0, 1) == 1);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
